genbus_master: RTL and testbench
================================

GENBUS_MASTER -- requirements
Module: genbus_master

Interface
REQ-001 SHALL have parameter ID, default 0: initiator identifier, reported unchanged on output mid.
REQ-002 SHALL have parameter TIMEOUT, default 15: maximum consecutive wait-state cycles before abort; 0 disables the timeout.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid  input  1  command request from the local requester.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high at a clk edge.
REQ-007 SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-008 SHALL have port cmd_be  input  2  byte enables; bit0 = data[7:0], bit1 = data[15:8].
REQ-009 SHALL have port cmd_adr  input  16  transfer address.
REQ-010 SHALL have port cmd_wdata  input  16  write data.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata  output  16  read data; valid when rsp_valid is high.
REQ-013 SHALL have port rsp_err  output  1  timeout abort flag; valid when rsp_valid is high.
REQ-014 SHALL have port mid  output  8  ID[7:0], constant.
REQ-015 SHALL have port adr  output  16  bus address.
REQ-016 SHALL have port mdata  output  16  bus write data.
REQ-017 SHALL have port we  output  2  bus per-byte write strobes.
REQ-018 SHALL have port re  output  2  bus per-byte read strobes.
REQ-019 SHALL have port sdata  input  16  read data returned by the selected slave.
REQ-020 SHALL have port ws  input  1  slave wait-state request; 1 = extend the access.

Function
REQ-021 SHALL implement FSM states IDLE, ACCESS and RESP; reset state is IDLE.
REQ-022 SHALL drive cmd_ready = 1 only in IDLE; commands are not accepted in any other state.
REQ-023 SHALL, on acceptance with cmd_be != 0, register adr, mdata and the strobes, then enter ACCESS; the strobes are we = cmd_be and re = 0 for a write, and re = cmd_be and we = 0 for a read.
REQ-024 SHALL, on acceptance with cmd_be == 0, skip ACCESS, enter RESP directly, and drive no strobes; rsp_rdata = 0 and rsp_err = 0.
REQ-025 SHALL hold adr, mdata, we and re stable for every cycle in ACCESS.
REQ-026 SHALL, in ACCESS with ws == 0 sampled at a clk edge, complete the transfer: register read data, clear we and re, and enter RESP.
REQ-027 SHALL register read data per byte from sdata where the corresponding cmd_be bit is 1; disabled bytes are 0; writes return rsp_rdata = 0.
REQ-028 SHALL, in ACCESS with ws == 1, increment a wait counter of width $clog2(TIMEOUT+1), minimum 1, that starts at 0 on entry to ACCESS.
REQ-029 SHALL, when TIMEOUT != 0 and ws == 1 with the counter equal to TIMEOUT-1, abort: clear the strobes, set rsp_err = 1 with rsp_rdata = 0, and enter RESP.
REQ-030 SHALL never let the wait counter wrap; with TIMEOUT == 0 it saturates at its maximum value and the access waits indefinitely.
REQ-031 SHALL assert rsp_valid for exactly one cycle, in RESP, then return to IDLE.
REQ-032 SHALL meet latency: accept at edge N; strobes visible after edge N; with zero waits, rsp_valid is high after edge N+1; each wait cycle adds one cycle.
REQ-033 SHALL give a minimum command-to-command period of 3 cycles (IDLE, ACCESS, RESP).
REQ-034 SHALL hold the registered adr and mdata after completion until the next acceptance.
REQ-035 SHALL never assert we and re simultaneously.

Reset
REQ-036 SHALL, on rst low and asynchronously, set the state to IDLE and drive cmd_ready = 0 while rst is low, with rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, adr = 0, mdata = 0, we = 0, re = 0, and wait counter = 0.
REQ-037 SHALL abandon a transfer interrupted by reset without producing a response; cmd_ready = 1 at the first clk edge after rst rises.

Verification
REQ-038 SHALL cover a write: cmd_adr = 0x0004, cmd_be = 11, cmd_wdata = 0xA55A, ws = 0 -> for exactly 1 cycle adr = 0x0004, we = 11, mdata = 0xA55A; next cycle rsp_valid = 1 and rsp_err = 0.
REQ-039 SHALL cover a read with 3 waits: cmd_be = 01, ws = 1 for 3 cycles then 0, sdata = 0x12C3 -> re = 01 held for 4 cycles; rsp_rdata = 0x00C3.
REQ-040 SHALL cover a timeout with TIMEOUT = 4: ws stuck at 1 -> strobes high for 4 cycles then 0; rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
REQ-041 SHALL cover zero byte enables: cmd_be = 00 -> we = re = 00 throughout; rsp_valid = 1 one cycle after acceptance, rsp_rdata = 0.
REQ-042 SHALL cover reset mid-access: rst low during a wait state -> we, re and rsp_valid are 0 immediately with no response; after rst rises, a new command completes normally.
REQ-043 SHALL cover back-to-back traffic: cmd_valid held high for 4 commands with ws = 0 -> acceptances exactly 3 cycles apart and 4 rsp_valid pulses.

Source files
------------

// File: rtl/genbus_master.sv
// genbus_master: single-outstanding bus initiator (IDLE/ACCESS/RESP).
// Ports: cmd_* request, rsp_* completion, adr/mdata/we/re/sdata/ws bus.
module genbus_master #(
  parameter int unsigned ID      = 0,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_be,
  input  logic [15:0] cmd_adr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  mid,
  output logic [15:0] adr,
  output logic [15:0] mdata,
  output logic [1:0]  we,
  output logic [1:0]  re,
  input  logic [15:0] sdata,
  input  logic        ws
);

  localparam int CLOG = $clog2(TIMEOUT + 1);
  localparam int CW   = (CLOG < 1) ? 1 : CLOG;
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(TO_EN ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [31:0] IDW = 32'(ID);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   adr_q, adr_d;
  logic [15:0]   mdata_q, mdata_d;
  logic [1:0]    we_q, we_d;
  logic [1:0]    re_q, re_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   rd_bytes;

  // Read strobes double as the byte mask for returned data;
  // they are zero for writes, so writes return 0.
  assign rd_bytes = {
    re_q[1] ? sdata[15:8] : 8'h00,
    re_q[0] ? sdata[7:0]  : 8'h00
  };

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    mdata_d = mdata_q;
    we_d    = we_q;
    re_d    = re_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          rdata_d = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          if (cmd_be != 2'b00) begin
            adr_d   = cmd_adr;
            mdata_d = cmd_wdata;
            we_d    = cmd_write ? cmd_be : 2'b00;
            re_d    = cmd_write ? 2'b00 : cmd_be;
            state_d = ACCESS;
          end else begin
            state_d = RESP;
          end
        end
      end
      ACCESS: begin
        if (!ws) begin
          rdata_d = rd_bytes;
          we_d    = 2'b00;
          re_d    = 2'b00;
          state_d = RESP;
        end else if (TO_EN && cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          we_d    = 2'b00;
          re_d    = 2'b00;
          state_d = RESP;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      adr_q   <= '0;
      mdata_q <= '0;
      we_q    <= '0;
      re_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      mdata_q <= mdata_d;
      we_q    <= we_d;
      re_q    <= re_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Ready is gated by reset so it reads low while rst is held.
  assign cmd_ready = (state_q == IDLE) && rst;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mid       = IDW[7:0];
  assign adr       = adr_q;
  assign mdata     = mdata_q;
  assign we        = we_q;
  assign re        = re_q;

endmodule

// File: tb/tb_genbus_master.sv
// tb_genbus_master: directed vectors for genbus_master.
// Runs TIMEOUT=4 so the abort path is reachable quickly.
module tb_genbus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [1:0]  cmd_be = 2'b00;
  logic [15:0] cmd_adr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  mid;
  logic [15:0] adr;
  logic [15:0] mdata;
  logic [1:0]  we;
  logic [1:0]  re;
  logic [15:0] sdata = '0;
  logic        ws = 1'b0;

  int total = 0;
  int bad = 0;

  genbus_master #(.ID(8'h5A), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_be(cmd_be),
    .cmd_adr(cmd_adr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mid(mid),
    .adr(adr), .mdata(mdata), .we(we), .re(re),
    .sdata(sdata), .ws(ws)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  be;
    logic [15:0] adr;
    logic [15:0] wdata;
    logic [15:0] sdata;
    int          nwait;
    logic [15:0] erd;
    logic        eerr;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic run_cmd(input int id, input vec_t v);
    int k;
    int exp_k;
    logic [1:0] ewe;
    logic [1:0] ere;
    ewe = v.wr ? v.be : 2'b00;
    ere = v.wr ? 2'b00 : v.be;
    if (v.be == 2'b00) exp_k = 0;
    else if (v.nwait >= 4) exp_k = 4;
    else exp_k = v.nwait + 1;
    @(negedge clk);
    chk($sformatf("v%0d ready", id), 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_be    = v.be;
    cmd_adr   = v.adr;
    cmd_wdata = v.wdata;
    sdata     = v.sdata;
    ws        = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 0;
    while (!rsp_valid) begin
      if (k > 20) begin
        chk($sformatf("v%0d rsp_timeout", id), 32'(k), 32'(exp_k));
        break;
      end
      chk($sformatf("v%0d adr", id), 32'(adr), 32'(v.adr));
      chk($sformatf("v%0d mdata", id), 32'(mdata), 32'(v.wdata));
      chk($sformatf("v%0d we", id), 32'(we), 32'(ewe));
      chk($sformatf("v%0d re", id), 32'(re), 32'(ere));
      ws = (k < v.nwait);
      k++;
      @(negedge clk);
    end
    ws = 1'b0;
    chk($sformatf("v%0d strobe_cycles", id), 32'(k), 32'(exp_k));
    chk($sformatf("v%0d rdata", id), 32'(rsp_rdata), 32'(v.erd));
    chk($sformatf("v%0d err", id), 32'(rsp_err), 32'(v.eerr));
    chk($sformatf("v%0d rsp_we", id), 32'(we), 0);
    chk($sformatf("v%0d rsp_re", id), 32'(re), 0);
    @(negedge clk);
    chk($sformatf("v%0d pulse", id), 32'(rsp_valid), 0);
    chk($sformatf("v%0d ready2", id), 32'(cmd_ready), 1);
    if (v.be != 2'b00)
      chk($sformatf("v%0d adr_hold", id), 32'(adr), 32'(v.adr));
  endtask

  initial begin
    int acc[4];
    int n;
    int pulses;
    vecs[0] = '{1'b1, 2'b11, 16'h0004, 16'hA55A, 16'h0000,
                0, 16'h0000, 1'b0};
    vecs[1] = '{1'b0, 2'b01, 16'h0010, 16'h0000, 16'h12C3,
                3, 16'h00C3, 1'b0};
    vecs[2] = '{1'b0, 2'b11, 16'h1234, 16'h0000, 16'hBEEF,
                99, 16'h0000, 1'b1};
    vecs[3] = '{1'b1, 2'b00, 16'h0F00, 16'h7777, 16'hFFFF,
                0, 16'h0000, 1'b0};
    vecs[4] = '{1'b0, 2'b10, 16'h0022, 16'h0000, 16'h12C3,
                0, 16'h1200, 1'b0};
    vecs[5] = '{1'b1, 2'b01, 16'h0030, 16'h00FE, 16'hFFFF,
                2, 16'h0000, 1'b0};
    vecs[6] = '{1'b0, 2'b11, 16'h0032, 16'h0000, 16'h5AA5,
                3, 16'h5AA5, 1'b0};
    vecs[7] = '{1'b0, 2'b00, 16'h0040, 16'h0000, 16'hFFFF,
                0, 16'h0000, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst ready", 32'(cmd_ready), 0);
    chk("rst valid", 32'(rsp_valid), 0);
    chk("rst err", 32'(rsp_err), 0);
    chk("rst rdata", 32'(rsp_rdata), 0);
    chk("rst adr", 32'(adr), 0);
    chk("rst mdata", 32'(mdata), 0);
    chk("rst we", 32'(we), 0);
    chk("rst re", 32'(re), 0);
    chk("mid", 32'(mid), 32'h5A);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) run_cmd(i, vecs[i]);

    // Reset during a wait state: strobes drop at once, no response.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_be    = 2'b11;
    cmd_adr   = 16'h0040;
    ws        = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid_rst pre re", 32'(re), 32'h3);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst we", 32'(we), 0);
    chk("mid_rst re", 32'(re), 0);
    chk("mid_rst valid", 32'(rsp_valid), 0);
    chk("mid_rst ready", 32'(cmd_ready), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst no_rsp", 32'(rsp_valid), 0);
    end
    ws = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 chk("post_rst ready", 32'(cmd_ready), 1);
    run_cmd(8, vecs[0]);

    // Back-to-back: cmd_valid held for four commands.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_be    = 2'b11;
    cmd_adr   = 16'h0050;
    cmd_wdata = 16'h1357;
    ws        = 1'b0;
    n = 0;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      if (n == 4) cmd_valid = 1'b0;
      if (rsp_valid) pulses++;
      chk("b2b we_re", 32'(we & re), 0);
      if (cmd_valid && cmd_ready) begin
        acc[n] = c;
        n++;
      end
      @(negedge clk);
    end
    chk("b2b accepts", 32'(n), 4);
    chk("b2b pulses", 32'(pulses), 4);
    for (int i = 1; i < 4; i++)
      chk($sformatf("b2b gap%0d", i),
          32'(acc[i] - acc[i-1]), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
